// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
package imm_pkg;

  // Format select codes carried on imm_sel; 9-15 are illegal.
  typedef enum logic [3:0] {
    IMM_I    = 4'd0,
    IMM_IU   = 4'd1,
    IMM_SH   = 4'd2,
    IMM_S    = 4'd3,
    IMM_B    = 4'd4,
    IMM_U    = 4'd5,
    IMM_J    = 4'd6,
    IMM_Z    = 4'd7,
    IMM_AUTO = 4'd8
  } imm_fmt_e;

  // RV32/RV64 base opcodes recognised by the auto-decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Sign-extension helpers to the widest supported datapath; callers truncate to XLEN.
  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  function automatic logic [63:0] sext13(input logic [12:0] v);
    return {{51{v[12]}}, v};
  endfunction

  function automatic logic [63:0] sext21(input logic [20:0] v);
    return {{43{v[20]}}, v};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode_xlen.sv
// Combinational immediate decoder: resolves the format (explicit or from the
// opcode) and assembles the XLEN-wide immediate. Error entries yield zeros.
module imm_decode_xlen
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit AUTO_EN = 1'b1
) (
  input  logic [31:0]     i_inst,
  input  logic [3:0]      i_imm_sel,
  output logic [XLEN-1:0] o_imm,
  output logic            o_err,
  output logic [2:0]      o_fmt
);

  // Shift-amount width follows the datapath and is deliberately not a parameter.
  localparam int SHW = (XLEN == 64) ? 6 : 5;
  localparam logic [5:0] SH_MASK = 6'((1 << SHW) - 1);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
      $error("imm_decode_xlen: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [2:0]      w_fmt;
  logic            w_err;
  logic [XLEN-1:0] w_imm;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];

  // Resolve the effective format; anything that cannot be resolved is an error.
  always_comb begin
    w_err = 1'b0;
    w_fmt = 3'd0;
    if (!i_imm_sel[3]) begin
      w_fmt = i_imm_sel[2:0];
    end else if (i_imm_sel == IMM_AUTO && AUTO_EN) begin
      unique case (w_opcode)
        OP_LOAD, OP_JALR: w_fmt = 3'(IMM_I);
        OP_IMM:           w_fmt = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? 3'(IMM_SH) : 3'(IMM_I);
        OP_STORE:         w_fmt = 3'(IMM_S);
        OP_BRANCH:        w_fmt = 3'(IMM_B);
        OP_LUI, OP_AUIPC: w_fmt = 3'(IMM_U);
        OP_JAL:           w_fmt = 3'(IMM_J);
        OP_SYSTEM:        w_fmt = w_funct3[2] ? 3'(IMM_Z) : 3'(IMM_IU);
        default:          w_err = 1'b1;
      endcase
    end else begin
      w_err = 1'b1;
    end
  end

  // Assemble the immediate for the resolved format.
  always_comb begin
    w_imm = '0;
    if (!w_err) begin
      case (w_fmt)
        3'(IMM_I):  w_imm = XLEN'(sext12(i_inst[31:20]));
        3'(IMM_IU): w_imm = XLEN'({52'b0, i_inst[31:20]});
        3'(IMM_SH): w_imm = XLEN'({58'b0, i_inst[25:20] & SH_MASK});
        3'(IMM_S):  w_imm = XLEN'(sext12({i_inst[31:25], i_inst[11:7]}));
        3'(IMM_B):  w_imm = XLEN'(sext13({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
        3'(IMM_U):  w_imm = XLEN'(sext32({i_inst[31:12], 12'b0}));
        3'(IMM_J):  w_imm = XLEN'(sext21({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
        default:    w_imm = XLEN'({59'b0, i_inst[19:15]});
      endcase
    end
  end

  assign o_imm = w_imm;
  assign o_err = w_err;
  assign o_fmt = w_err ? 3'd0 : w_fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder followed by a registered output
// entry (A) and a skid entry (B). Outputs come only from registers.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit AUTO_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [3:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_err,
  output logic [2:0]      fmt_out
);

  logic [XLEN-1:0] w_dec_imm;
  logic            w_dec_err;
  logic [2:0]      w_dec_fmt;

  imm_decode_xlen #(
    .XLEN    (XLEN),
    .AUTO_EN (AUTO_EN)
  ) u_decode (
    .i_inst    (inst),
    .i_imm_sel (imm_sel),
    .o_imm     (w_dec_imm),
    .o_err     (w_dec_err),
    .o_fmt     (w_dec_fmt)
  );

  logic            r_a_valid;
  logic [XLEN-1:0] r_a_imm;
  logic            r_a_err;
  logic [2:0]      r_a_fmt;
  logic            r_b_valid;
  logic [XLEN-1:0] r_b_imm;
  logic            r_b_err;
  logic [2:0]      r_b_fmt;
  logic            r_in_ready;

  logic w_acc;
  logic w_drain;
  logic w_a_from_b;
  logic w_a_load;
  logic w_a_clear;
  logic w_b_load;
  logic w_b_clear;
  logic w_b_valid_next;

  assign w_acc   = in_valid && r_in_ready;
  assign w_drain = r_a_valid && out_ready;

  // Decide where this cycle's data moves: B refills A on drain, new data fills
  // A when it is free (or freeing) and B otherwise.
  always_comb begin
    w_a_from_b = 1'b0;
    w_a_load   = 1'b0;
    w_a_clear  = 1'b0;
    w_b_load   = 1'b0;
    w_b_clear  = 1'b0;
    if (w_drain) begin
      if (r_b_valid) begin
        w_a_from_b = 1'b1;
        if (w_acc) w_b_load = 1'b1;
        else       w_b_clear = 1'b1;
      end else if (w_acc) begin
        w_a_load = 1'b1;
      end else begin
        w_a_clear = 1'b1;
      end
    end else if (w_acc) begin
      if (r_a_valid) w_b_load = 1'b1;
      else           w_a_load = 1'b1;
    end
    w_b_valid_next = w_b_load || (r_b_valid && !w_b_clear);
  end

  // Entry registers and registered ready; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid  <= 1'b0;
      r_a_imm    <= '0;
      r_a_err    <= 1'b0;
      r_a_fmt    <= 3'd0;
      r_b_valid  <= 1'b0;
      r_b_imm    <= '0;
      r_b_err    <= 1'b0;
      r_b_fmt    <= 3'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_a_from_b) begin
        r_a_valid <= 1'b1;
        r_a_imm   <= r_b_imm;
        r_a_err   <= r_b_err;
        r_a_fmt   <= r_b_fmt;
      end else if (w_a_load) begin
        r_a_valid <= 1'b1;
        r_a_imm   <= w_dec_imm;
        r_a_err   <= w_dec_err;
        r_a_fmt   <= w_dec_fmt;
      end else if (w_a_clear) begin
        r_a_valid <= 1'b0;
      end
      if (w_b_load) begin
        r_b_imm <= w_dec_imm;
        r_b_err <= w_dec_err;
        r_b_fmt <= w_dec_fmt;
      end
      r_b_valid  <= w_b_valid_next;
      r_in_ready <= !w_b_valid_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_a_valid;
  assign imm_out   = r_a_imm;
  assign imm_err   = r_a_err;
  assign fmt_out   = r_a_fmt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, XLEN=32 without
// auto-decode) share one input stream; each has its own expected-result queue.
module tb_imm_gen_pipe;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] inst;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
    logic [2:0]  fmt;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic [3:0]  imm_sel;
  logic        out_ready;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [31:0] imm0;
  logic [63:0] imm1;
  logic [31:0] imm2;
  logic        err0, err1, err2;
  logic [2:0]  fmt0, fmt1, fmt2;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vecs[19];

  imm_gen_pipe #(.XLEN(32), .AUTO_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .inst(inst),
    .imm_sel(imm_sel), .out_valid(ov0), .out_ready(out_ready), .imm_out(imm0),
    .imm_err(err0), .fmt_out(fmt0));

  imm_gen_pipe #(.XLEN(64), .AUTO_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .inst(inst),
    .imm_sel(imm_sel), .out_valid(ov1), .out_ready(out_ready), .imm_out(imm1),
    .imm_err(err1), .fmt_out(fmt1));

  imm_gen_pipe #(.XLEN(32), .AUTO_EN(1'b0)) dutna (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .inst(inst),
    .imm_sel(imm_sel), .out_valid(ov2), .out_ready(out_ready), .imm_out(imm2),
    .imm_err(err2), .fmt_out(fmt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input vec_t v);
    q0.push_back('{imm: 64'(v.e32), err: v.err, fmt: v.fmt});
    q1.push_back('{imm: v.e64, err: v.err, fmt: v.fmt});
    if (v.sel == 4'd8) q2.push_back('{imm: 64'd0, err: 1'b1, fmt: 3'd0});
    else               q2.push_back('{imm: 64'(v.e32), err: v.err, fmt: v.fmt});
  endfunction

  task automatic check_out(input int which, input logic [63:0] imm, input logic err,
                           input logic [2:0] fmt);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d unexpected output: got imm=%0h err=%0b, expected no entry", which, imm, err);
    end else begin
      if (which == 0)      e = q0.pop_front();
      else if (which == 1) e = q1.pop_front();
      else                 e = q2.pop_front();
      $display("rx dut%0d imm=%0h err=%0b fmt=%0d", which, imm, err, fmt);
      chk($sformatf("dut%0d imm_out", which), imm, e.imm);
      chk($sformatf("dut%0d imm_err", which), 64'(err), 64'(e.err));
      chk($sformatf("dut%0d fmt_out", which), 64'(fmt), 64'(e.fmt));
    end
  endtask

  // Output monitor: an output transfer happens on the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ov0) check_out(0, 64'(imm0), err0, fmt0);
      if (ov1) check_out(1, imm1, err1, fmt1);
      if (ov2) check_out(2, 64'(imm2), err2, fmt2);
    end
  end

  task automatic send(input vec_t v);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    inst = v.inst;
    imm_sel = v.sel;
    while (!acc && budget < 50) begin
      @(negedge clk);
      if (ir0) begin
        acc = 1'b1;
        push_exp(v);
      end
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send timeout: in_ready stayed 0, required 1 within 50 cycles");
    end else begin
      $display("tx sel=%0d inst=%08h", v.sel, v.inst);
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_imm;
    logic        s_err;
    logic [2:0]  s_fmt;
    bit          acc;

    //            sel    inst          e32           e64                    err   fmt
    vecs[0]  = '{4'd0,  32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0};
    vecs[1]  = '{4'd8,  32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 3'd4};
    vecs[2]  = '{4'd8,  32'h123450B7, 32'h12345000, 64'h0000000012345000, 1'b0, 3'd5};
    vecs[3]  = '{4'd8,  32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 3'd5};
    vecs[4]  = '{4'd2,  32'h03F09093, 32'h0000001F, 64'h000000000000003F, 1'b0, 3'd2};
    vecs[5]  = '{4'd8,  32'h03F09093, 32'h0000001F, 64'h000000000000003F, 1'b0, 3'd2};
    vecs[6]  = '{4'd10, 32'hFFF00093, 32'h00000000, 64'h0000000000000000, 1'b1, 3'd0};
    vecs[7]  = '{4'd8,  32'h0000007F, 32'h00000000, 64'h0000000000000000, 1'b1, 3'd0};
    vecs[8]  = '{4'd1,  32'hFFF00093, 32'h00000FFF, 64'h0000000000000FFF, 1'b0, 3'd1};
    vecs[9]  = '{4'd3,  32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 3'd3};
    vecs[10] = '{4'd6,  32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 3'd6};
    vecs[11] = '{4'd7,  32'h000AD073, 32'h00000015, 64'h0000000000000015, 1'b0, 3'd7};
    vecs[12] = '{4'd8,  32'h000AD073, 32'h00000015, 64'h0000000000000015, 1'b0, 3'd7};
    vecs[13] = '{4'd8,  32'h30002573, 32'h00000300, 64'h0000000000000300, 1'b0, 3'd1};
    vecs[14] = '{4'd8,  32'hFFC12083, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 3'd0};
    vecs[15] = '{4'd5,  32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 3'd5};
    vecs[16] = '{4'd4,  32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 3'd4};
    vecs[17] = '{4'd8,  32'h80008067, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, 3'd0};
    vecs[18] = '{4'd15, 32'h00000013, 32'h00000000, 64'h0000000000000000, 1'b1, 3'd0};

    rst = 1'b1;
    in_valid = 1'b0;
    inst = 32'd0;
    imm_sel = 4'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // A transfer presented during the reset cycle must be dropped.
    in_valid = 1'b1;
    inst = 32'hFFF00093;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    chk("reset out_valid", 64'(ov0), 64'd0);
    chk("reset in_ready", 64'(ir0), 64'd1);
    chk("reset imm_out", 64'(imm0), 64'd0);
    chk("reset imm_err", 64'(err0), 64'd0);
    chk("reset fmt_out", 64'(fmt0), 64'd0);
    chk("reset out_valid64", 64'(ov1), 64'd0);
    chk("reset imm_out64", imm1, 64'd0);
    @(posedge clk);
    #1;
    chk("reset-cycle input dropped", 64'(ov0), 64'd0);

    // Streaming table with the consumer always ready; one-cycle latency each.
    foreach (vecs[i]) begin
      send(vecs[i]);
      chk($sformatf("latency vec%0d", i), 64'(ov0), 64'd1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: three back-to-back entries with the consumer stalled.
    out_ready = 1'b0;
    send(vecs[0]);
    chk("bp in_ready after 1st", 64'(ir0), 64'd1);
    send(vecs[1]);
    chk("bp in_ready after 2nd", 64'(ir0), 64'd0);
    chk("bp head imm", 64'(imm0), 64'(vecs[0].e32));
    s_imm = imm0;
    s_err = err0;
    s_fmt = fmt0;
    in_valid = 1'b1;
    inst = vecs[2].inst;
    imm_sel = vecs[2].sel;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp in_ready held low", 64'(ir0), 64'd0);
      chk("bp imm stable", 64'(imm0), 64'(s_imm));
      chk("bp err stable", 64'(err0), 64'(s_err));
      chk("bp fmt stable", 64'(fmt0), 64'(s_fmt));
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp no gap %0d", k), 64'(ov0), 64'd1);
      if (!acc && ir0) begin
        acc = 1'b1;
        push_exp(vecs[2]);
        $display("tx sel=%0d inst=%08h", vecs[2].sel, vecs[2].inst);
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    chk("bp 3rd accepted", 64'(acc), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Reset with both entries full; nothing stale may emerge afterwards.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    chk("mid-reset both full", 64'(ir0), 64'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    inst = vecs[5].inst;
    imm_sel = vecs[5].sel;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    chk("mid-reset out_valid", 64'(ov0), 64'd0);
    chk("mid-reset in_ready", 64'(ir0), 64'd1);
    chk("mid-reset imm_out", 64'(imm0), 64'd0);
    chk("mid-reset imm_out64", imm1, 64'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post-reset idle", 64'(ov0), 64'd0);
    end
    send(vecs[6]);
    chk("post-reset latency", 64'(ov0), 64'd1);
    repeat (4) @(posedge clk);
    #1;

    chk("dut32 queue drained", 64'(q0.size()), 64'd0);
    chk("dut64 queue drained", 64'(q1.size()), 64'd0);
    chk("dutna queue drained", 64'(q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate generator. It takes a 32-bit RISC-V instruction and a format select, or auto-decodes the format from the opcode. It produces an XLEN-wide immediate through a registered valid/ready stage with a 2-entry skid buffer. It sits between fetch/decode and the operand mux of the pipelined core.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal, anything else is an elaboration error.
AUTO_EN, 1, 1 enables opcode auto-decode (imm_sel=4'b1000); 0 makes that select an error.
SHW, (XLEN==64)?6:5, derived shift-amount width; not overridable.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  inst/imm_sel valid.
in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
inst  in  32  instruction word.
imm_sel  in  4  format select (encoding below).
out_valid  out  1  imm_out/imm_err valid.
out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
imm_out  out  XLEN  generated immediate.
imm_err  out  1  unsupported select or opcode for this entry.
fmt_out  out  3  resolved format code (0-7) for this entry.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, in_ready=1, imm_out=0, imm_err=0, fmt_out=0.
  - Both buffer entries are invalidated. Any in-flight data is dropped, including a transfer presented in the reset cycle.
- Select encoding (fmt; sign-extension always from inst[31] to XLEN):
  - 0: I signed, inst[31:20].
  - 1: I zero-extended, inst[31:20].
  - 2: shamt, zero-extended inst[20+SHW-1:20]. XLEN=32 uses [24:20]; XLEN=64 uses [25:20].
  - 3: S, {inst[31:25],inst[11:7]} signed.
  - 4: B, {inst[31],inst[7],inst[30:25],inst[11:8],0} signed.
  - 5: U, {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - 6: J, {inst[31],inst[19:12],inst[20],inst[30:21],0} signed.
  - 7: CSR zimm, zero-extended inst[19:15].
  - 8: AUTO.
  - 9-15: illegal.
- AUTO decode on inst[6:0]:
  - 0000011, 1100111 -> fmt 0.
  - 0010011: funct3 001/101 -> fmt 2, else fmt 0.
  - 0100011 -> 3.
  - 1100011 -> 4.
  - 0110111, 0010111 -> 5.
  - 1101111 -> 6.
  - 1110011: funct3[2]=1 -> 7, else 1.
  - Any other opcode -> error.
- Error entries (illegal select, AUTO with AUTO_EN=0, unknown opcode): imm_out=0, imm_err=1, fmt_out=0. The entry still flows through the pipe and is never dropped.
- Latency:
  - An accepted input appears on the outputs exactly 1 cycle later when the output register is empty or draining.
  - Outputs are driven only from registers, with no combinational path from inst to imm_out.
- Buffering:
  - Output register (entry A) plus skid register (entry B).
  - in_ready is registered: in_ready = !B_valid.
  - If input is accepted while A is valid and not draining, the data goes to B.
  - When A drains and B is valid, B moves to A on the same edge.
  - Strict FIFO order; no entry is lost or duplicated.
- Simultaneous events:
  - Accept and drain in one cycle with B empty: A is replaced by the new entry and out_valid stays 1.
  - Accept while B is full cannot happen, because in_ready=0.
- Stability: while out_valid=1 && out_ready=0, imm_out, imm_err and fmt_out hold stable.

Decomposition:
- Shared package imm_pkg:
  - Format enum IMM_I, IMM_IU, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_AUTO.
  - Opcode constants OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM.
- One combinational sub-module imm_decode_xlen (XLEN param): inst, imm_sel -> imm, err, fmt.
- The top level holds only the skid/handshake registers.

Test Plan:
- XLEN=32, sel=0, inst=0xFFF00093 -> 1 cycle later out_valid=1, imm_out=0xFFFFFFFF, imm_err=0. With XLEN=64 the result is 0xFFFFFFFFFFFFFFFF.
- sel=8 (AUTO):
  - inst=0xFE000EE3 -> imm_out=0xFFFFFFFC, fmt_out=4.
  - inst=0x123450B7 -> 0x12345000, fmt 5.
  - XLEN=64, inst=0x80000037 -> 0xFFFFFFFF80000000.
- Shamt: inst=0x03F09093 with sel=2 -> 63 for XLEN=64 and 31 for XLEN=32. With sel=8 the result is also fmt 2.
- Errors:
  - sel=4'b1010 -> imm_err=1, imm_out=0.
  - AUTO with inst=0x0000007F -> imm_err=1.
  - AUTO_EN=0 with sel=8 -> imm_err=1.
- Backpressure: hold out_ready=0 and present 3 back-to-back valid inputs.
  - in_ready goes 0 after the 2nd accept.
  - Outputs stay stable.
  - Releasing out_ready yields entries 1, 2, 3 in order with no gaps once the 3rd is accepted.
- Reset mid-operation: assert rst for 1 cycle with A and B both full.
  - Next cycle: out_valid=0, in_ready=1, imm_out=0.
  - No stale entry appears afterwards.
